mem_access_unit: RTL and testbench

//  Load/store unit between the core execute stage and the word-wide program/data memory.

---
 rtl/mem_access_unit_if.sv | 35 +++
 rtl/mem_access_unit.sv | 173 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundle of core request/response and memory-side signals for mem_access_unit.
// slave  : the load/store unit (takes requests, drives memory strobes)
// master : the core plus memory model (issues requests, returns mem_rdata)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : core request handshake
//   rsp_valid/rsp_err/rsp_rdata                               : completion pulse and data
//   mem_addr/mem_wdata/mem_rd_strobe/mem_wr_strobe/mem_rdata  : word-wide memory port
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_strobe;
  logic [3:0]  mem_wr_strobe;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_addr, mem_wdata, mem_rd_strobe, mem_wr_strobe
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit between the execute stage and a word-wide, registered-read memory.
// Accepts one byte/halfword/word request at a time, drives word address, lane-replicated
// write data and byte strobes, then returns sign/zero-extended load data.
// Misaligned, out-of-range or illegal-funct3 requests are answered with rsp_err in one
// cycle and never touch memory.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mem_access_unit_if.slave (request, response and memory signals)
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic               clk,
  input logic               rst,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StLdWait} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rd_q, rd_d;
  logic [3:0]  wr_q, wr_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        legal_f3, misaligned, out_of_range, illegal;
  logic [3:0]  lane_mask;
  logic [31:0] lane_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request legality
  always_comb begin
    if (bus.req_we) legal_f3 = (bus.req_funct3 <= 3'd2);
    else            legal_f3 = (bus.req_funct3 != 3'd3) && (bus.req_funct3 < 3'd6);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = (bus.req_addr >= MEM_BYTES);
    illegal      = !legal_f3 || misaligned || out_of_range;
  end

  // Store lane replication and byte strobes
  always_comb begin
    case (bus.req_funct3[1:0])
      2'b00: begin
        lane_wdata = {4{bus.req_wdata[7:0]}};
        lane_mask  = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{bus.req_wdata[15:0]}};
        lane_mask  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_wdata = bus.req_wdata;
        lane_mask  = 4'b1111;
      end
    endcase
  end

  // Load lane extraction using the offset latched at accept
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = 1'b0;
    wr_d        = 4'b0000;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          if (illegal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
          end else begin
            we_d        = bus.req_we;
            funct3_d    = bus.req_funct3;
            off_d       = bus.req_addr[1:0];
            mem_addr_d  = {bus.req_addr[31:2], 2'b00};
            mem_wdata_d = lane_wdata;
            if (bus.req_we) wr_d = lane_mask;
            else            rd_d = 1'b1;
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 32'd0;
          state_d     = StIdle;
        end else begin
          state_d = StLdWait;
        end
      end
      StLdWait: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = ld_data;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rd_q        <= 1'b0;
      wr_q        <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready     = (state_q == StIdle);
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_rd_strobe = rd_q;
  assign bus.mem_wr_strobe = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a byte-array reference model predicts every
// response and memory strobe at issue time; a negedge monitor pops and compares.
module tb_mem_access_unit;

  localparam int unsigned MemBytes = 4096;

  logic clk;
  logic rst;
  int   cyc = 0;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(MemBytes)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rd;
    int          acc;
  } str_t;

  rsp_t rsp_q[$];
  str_t str_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] pattern(input int unsigned idx);
    return (32'(idx) * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
  endfunction

  // Memory model: 1-cycle registered read, byte-writable; untouched words read as pattern()
  logic [31:0] mem_w [1024];
  bit          mem_v [1024];

  always @(posedge clk) begin
    logic [31:0] cur;
    int unsigned idx;
    idx = 32'(bus.mem_addr[11:2]);
    cur = mem_v[idx] ? mem_w[idx] : pattern(idx);
    if (|bus.mem_wr_strobe) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_wr_strobe[i]) cur[8*i +: 8] = bus.mem_wdata[8*i +: 8];
      mem_w[idx] <= cur;
      mem_v[idx] <= 1'b1;
    end
    if (bus.mem_rd_strobe) bus.mem_rdata <= cur;
  end

  // Reference model: flat byte array, predicts response and memory activity
  logic [7:0] ref_mem [MemBytes];

  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int acc);
    int unsigned size;
    bit          legal;
    logic [31:0] word, wd, val;
    logic [3:0]  mask;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    legal = legal && (addr % size == 0) && (addr < MemBytes);
    word  = addr & ~32'd3;
    if (!legal) begin
      rsp_q.push_back('{err: 1'b1, rdata: 32'd0, lat: 1, acc: acc});
    end else if (we) begin
      wd   = 32'd0;
      mask = 4'd0;
      for (int i = 0; i < 4; i++) begin
        wd[8*i +: 8] = wdata[8*(i % size) +: 8];
        if (i >= int'(addr % 4) && i < int'(addr % 4 + size)) begin
          mask[i] = 1'b1;
          ref_mem[word + 32'(i)] = wd[8*i +: 8];
        end
      end
      str_q.push_back('{addr: word, wdata: wd, wstrb: mask, rd: 1'b0, acc: acc});
      rsp_q.push_back('{err: 1'b0, rdata: 32'd0, lat: 2, acc: acc});
    end else begin
      val = 32'd0;
      for (int i = 0; i < int'(size); i++) val[8*i +: 8] = ref_mem[addr + 32'(i)];
      if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 1);
      str_q.push_back('{addr: word, wdata: 32'd0, wstrb: 4'd0, rd: 1'b1, acc: acc});
      rsp_q.push_back('{err: 1'b0, rdata: val, lat: 3, acc: acc});
    end
  endtask

  // Monitor
  logic prev_strobe = 1'b0;

  always @(negedge clk) begin
    rsp_t r;
    str_t s;
    logic strobe;
    if (!rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (bus.rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          check("rsp_rdata", bus.rsp_rdata, r.rdata);
          check("rsp_latency", 32'(cyc - r.acc + 1), 32'(r.lat));
        end
      end
      strobe = bus.mem_rd_strobe || (|bus.mem_wr_strobe);
      if (strobe) begin
        check("strobe_width", 32'(prev_strobe), 32'd0);
        if (str_q.size() == 0) begin
          check("unexpected_strobe", 32'(strobe), 32'd0);
        end else begin
          s = str_q.pop_front();
          check("mem_addr", bus.mem_addr, s.addr);
          check("mem_rd_strobe", 32'(bus.mem_rd_strobe), 32'(s.rd));
          check("mem_wr_strobe", 32'(bus.mem_wr_strobe), 32'(s.wstrb));
          if (!s.rd) check("mem_wdata", bus.mem_wdata, s.wdata);
          check("strobe_cycle", 32'(cyc), 32'(s.acc));
        end
      end
      prev_strobe = strobe;
    end
  end

  // Called just after a negedge; returns just after the negedge following acceptance,
  // leaving req_valid high so back-to-back calls keep it asserted.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    acc = -1;
    for (int w = 0; w < 20 && acc < 0; w++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        model(we, f3, addr, wdata, acc);
      end
      @(negedge clk);
    end
    check("accept_in_time", 32'(acc >= 0), 32'd1);
  endtask

  task automatic idle(input int n);
    bus.req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int          acc, prev_acc;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int unsigned r;

    for (int a = 0; a < int'(MemBytes); a++) ref_mem[a] = pattern(a / 4) >> (8 * (a % 4));

    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    repeat (2) @(negedge clk);

    check("reset_req_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    check("reset_mem_wdata", bus.mem_wdata, 32'd0);
    check("reset_strobes", {27'd0, bus.mem_rd_strobe, bus.mem_wr_strobe}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Directed: store word, byte/half loads, halfword store, word reload
    issue(1'b1, 3'd2, 32'h100, 32'hDEAD_BEEF, acc); idle(3);
    issue(1'b0, 3'd0, 32'h103, 32'h0, acc);         idle(3);
    issue(1'b0, 3'd4, 32'h103, 32'h0, acc);         idle(3);
    issue(1'b0, 3'd5, 32'h100, 32'h0, acc);         idle(3);
    issue(1'b1, 3'd1, 32'h102, 32'h0000_1234, acc); idle(3);
    issue(1'b0, 3'd2, 32'h100, 32'h0, acc);         idle(3);

    // Errors: misaligned word/half, out of range, bad load funct3, bad store funct3
    issue(1'b0, 3'd2, 32'h101, 32'h0, acc);
    issue(1'b0, 3'd1, 32'h103, 32'h0, acc);
    issue(1'b0, 3'd1, 32'h1000, 32'h0, acc);
    issue(1'b0, 3'd3, 32'h100, 32'h0, acc);
    issue(1'b1, 3'd4, 32'h100, 32'h55, acc);
    idle(3);

    // req_valid held for back-to-back loads: one accept every 3 cycles
    prev_acc = -1;
    for (int i = 0; i < 10; i++) begin
      issue(1'b0, 3'd2, 32'h100, 32'h0, acc);
      if (i > 0) check("b2b_accept_gap", 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end
    idle(4);

    // Reset during LD_WAIT abandons the load
    issue(1'b0, 3'd2, 32'h100, 32'h0, acc);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #2;
    void'(rsp_q.pop_back());
    rst = 1'b0;
    #1;
    check("rst_mid_rd_strobe", 32'(bus.mem_rd_strobe), 32'd0);
    check("rst_mid_wr_strobe", 32'(bus.mem_wr_strobe), 32'd0);
    check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    issue(1'b1, 3'd0, 32'h104, 32'h0000_00A7, acc); idle(3);
    issue(1'b0, 3'd2, 32'h104, 32'h0, acc);         idle(4);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      r  = $urandom % 16;
      if (r == 0)      addr = MemBytes + ($urandom % 64);
      else if (r == 1) addr = $urandom;
      else begin
        addr = $urandom % MemBytes;
        if ($urandom % 4 != 0) addr = addr & ((f3[1:0] == 2'd0) ? ~32'd0 :
                                              (f3[1:0] == 2'd1) ? ~32'd1 : ~32'd3);
      end
      issue(we, f3, addr, $urandom, acc);
      if ($urandom % 3 == 0) idle(1 + ($urandom % 3));
    end
    idle(1);

    for (int w = 0; w < 20 && rsp_q.size() != 0; w++) @(negedge clk);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("strobe_queue_drained", 32'(str_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
